seg7_readback: RTL and testbench

Reads the multiplexed seven-segment drive lines of the stopwatch display and reconstructs the hex digit shown on each position. The segment encoder maps values to patterns; this block maps patterns back to values. It samples the shared segment bus and the one-hot digit enables, waits for each pattern to settle, and captures one digit per enable. When every digit has been captured, it presents a coherent frame with a one-cycle valid pulse. It is used for on-board self-test and for readback to the host.

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_readback.sv | 132 +++++++++++++
 tb/tb_seg7_readback.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern constants (same table as the encoder),
// frame FSM states and the one-hot index helper.
package seg7_pkg;

   localparam int MAX_DIGITS = 32;
   localparam int IDX_W      = 5;

   // Bit order {A,B,C,D,E,F,G}, A = bit 6. B and D alias 8 and 0 in the encoder.
   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h72;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7F;
   localparam logic [6:0] SEG_C = 7'h4E;
   localparam logic [6:0] SEG_D = 7'h7E;
   localparam logic [6:0] SEG_E = 7'h4F;
   localparam logic [6:0] SEG_F = 7'h47;

   typedef enum logic {
      COLLECT = 1'b0,
      PUBLISH = 1'b1
   } frame_state_e;

   // OR of the set-bit positions; exact only for a one-hot input.
   function automatic logic [IDX_W-1:0] onehot_index(input logic [MAX_DIGITS-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (v[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps a seven-segment pattern back to its hex value; unknown patterns flag invalid.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       invalid
);

   // B and D share the 8 and 0 patterns, so they come back as 8 and 0.
   always_comb begin
      nibble  = 4'h0;
      invalid = 1'b0;
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_C:   nibble = 4'hC;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_readback.sv
// Reconstructs the hex frame shown on a multiplexed seven-segment display by
// sampling the segment bus and digit enables and capturing each settled digit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   COLLECT | capturing digits until every position has been seen
//   PUBLISH | frame_valid high for one cycle; seen restarts for next frame
module seg7_readback
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   an,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   err,
   output logic                    frame_valid
);

   localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

   logic [6:0]              seg_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic [CNT_W-1:0]        cnt;
   logic                    same;
   logic                    in_onehot;
   logic                    capture;
   logic [MAX_DIGITS-1:0]   an_ext;
   logic [IDX_W-1:0]        cap_idx;
   logic [3:0]              dec_nib;
   logic                    dec_bad;
   logic [4*NUM_DIGITS-1:0] work_dig;
   logic [4*NUM_DIGITS-1:0] work_dig_nxt;
   logic [NUM_DIGITS-1:0]   work_err;
   logic [NUM_DIGITS-1:0]   work_err_nxt;
   logic [NUM_DIGITS-1:0]   seen;
   logic [NUM_DIGITS-1:0]   seen_nxt;
   frame_state_e            state;

   seg7_pattern_decode u_decode (
      .pattern (seg_q),
      .nibble  (dec_nib),
      .invalid (dec_bad)
   );

   // The dwell is judged on the sample being registered, so cnt reads 1 in the
   // same cycle seg_q/an_q first show a new value.
   always_comb begin
      same      = (seg == seg_q) && (an == an_q);
      in_onehot = $onehot(an);
      capture   = same && in_onehot && (cnt == CNT_ARM);
   end

   always_comb begin
      an_ext                 = '0;
      an_ext[NUM_DIGITS-1:0] = an_q;
      cap_idx                = onehot_index(an_ext);
   end

   always_comb begin
      work_dig_nxt = work_dig;
      work_err_nxt = work_err;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (capture && (cap_idx == IDX_W'(i))) begin
            work_dig_nxt[4*i +: 4] = dec_nib;
            work_err_nxt[i]        = dec_bad;
         end
      end
      seen_nxt = seen | (capture ? an_q : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q    <= '0;
         an_q     <= '0;
         cnt      <= '0;
         work_dig <= '0;
         work_err <= '0;
      end else begin
         seg_q    <= seg;
         an_q     <= an;
         work_dig <= work_dig_nxt;
         work_err <= work_err_nxt;
         if (!in_onehot)
            cnt <= '0;
         else if (!same)
            cnt <= CNT_W'(1);
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   // The frame is latched on the edge that completes it so frame_valid and
   // digits appear together in the PUBLISH cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= COLLECT;
         seen        <= '0;
         digits      <= '0;
         err         <= '0;
         frame_valid <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               seen <= seen_nxt;
               if (&seen_nxt) begin
                  digits      <= work_dig_nxt;
                  err         <= work_err_nxt;
                  frame_valid <= 1'b1;
                  state       <= PUBLISH;
               end
            end
            PUBLISH: begin
               seen        <= capture ? an_q : '0;
               frame_valid <= 1'b0;
               state       <= COLLECT;
            end
            default: begin
               seen        <= '0;
               frame_valid <= 1'b0;
               state       <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_readback.sv
// Randomised scoreboard bench for seg7_readback: a dwell/frame model predicts each
// published frame and its cycle; a monitor checks every output cycle.
module tb_seg7_readback;

   localparam int N = 4;
   localparam int S = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [6:0]     seg = '0;
   logic [N-1:0]   an  = '0;
   logic [4*N-1:0] digits;
   logic [N-1:0]   err;
   logic           frame_valid;

   seg7_readback #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .an          (an),
      .digits      (digits),
      .err         (err),
      .frame_valid (frame_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4*N-1:0] d;
      logic [N-1:0]   e;
      int             at;
   } frame_t;

   frame_t exp_q[$];
   bit     done = 1'b0;

   // Display patterns by value; B and D are drawn with the 8 and 0 shapes.
   logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
                            7'h7F, 7'h7B, 7'h77, 7'h7F, 7'h4E, 7'h7E, 7'h4F, 7'h47};

   logic [3:0]   m_nib [N];
   logic [N-1:0] m_err;
   logic [N-1:0] m_seen;
   logic [6:0]   p_seg;
   logic [N-1:0] p_an;
   int           run_len;
   int           run_start;

   // Lowest value drawing this shape wins, so the B/D shapes read as 8/0.
   task automatic model_decode(input logic [6:0] s, output logic [3:0] n, output logic e);
      n = 4'h0;
      e = 1'b1;
      for (int v = 15; v >= 0; v--) begin
         if (pat[v] == s) begin
            n = 4'(v);
            e = 1'b0;
         end
      end
   endtask

   task automatic model_capture(input logic [N-1:0] a, input logic [6:0] s, input int at);
      logic [3:0]     n;
      logic           e;
      frame_t         f;
      model_decode(s, n, e);
      for (int i = 0; i < N; i++) begin
         if (a[i]) begin
            m_nib[i]  = n;
            m_err[i]  = e;
            m_seen[i] = 1'b1;
         end
      end
      if (&m_seen) begin
         for (int i = 0; i < N; i++) f.d[4*i +: 4] = m_nib[i];
         f.e  = m_err;
         f.at = at;
         exp_q.push_back(f);
         m_seen = '0;
      end
   endtask

   // Drive one value for len cycles; called #1 after a rising edge.
   task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int len);
      if (!(s == p_seg && a == p_an)) begin
         run_len   = 0;
         run_start = cyc;
      end
      if ($onehot(a) && run_len < S && run_len + len >= S)
         model_capture(a, s, run_start + S);
      run_len += len;
      p_seg = s;
      p_an  = a;
      seg   = s;
      an    = a;
      repeat (len) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      seg = '0;
      an  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) m_nib[i] = 4'h0;
      m_err   = '0;
      m_seen  = '0;
      p_seg   = '0;
      p_an    = '0;
      run_len = 0;
   endtask

   task automatic scan(input int v0, input int v1, input int v2, input int v3, input int len);
      hold(4'b0001, pat[v0], len);
      hold(4'b0010, pat[v1], len);
      hold(4'b0100, pat[v2], len);
      hold(4'b1000, pat[v3], len);
   endtask

   initial begin
      logic [N-1:0] a;
      logic [N-1:0] bad_an [4];
      logic [6:0]   s;
      int           v;
      bad_an[0] = 4'b0000;
      bad_an[1] = 4'b0011;
      bad_an[2] = 4'b0110;
      bad_an[3] = 4'b1111;

      @(posedge clk);
      #1;
      do_reset();

      // Clean scan: 3,5,7,0 -> 16'h0753.
      hold(4'b0001, 7'h79, 8);
      hold(4'b0010, 7'h5B, 8);
      hold(4'b0100, 7'h72, 8);
      hold(4'b1000, 7'h7E, 8);

      // Glitch on digit 1, non-one-hot enables, blank pattern on digit 2.
      hold(4'b0001, 7'h5B, 8);
      hold(4'b0010, 7'h30, 2);
      hold(4'b0010, 7'h33, 6);
      hold(4'b0110, 7'h7E, 10);
      hold(4'b0100, 7'h00, 8);
      hold(4'b1000, 7'h30, 8);

      // B then D on digit 0.
      scan(11, 1, 2, 3, 6);
      scan(13, 4, 5, 6, 6);

      // Reset after three captures, then a full fresh scan.
      hold(4'b0001, pat[9], 8);
      hold(4'b0010, pat[10], 8);
      hold(4'b0100, pat[12], 8);
      do_reset();
      scan(14, 15, 1, 2, 7);

      // Continuous randomised scanning with glitches and bad enables.
      for (int f = 0; f < 30; f++) begin
         for (int d = 0; d < N; d++) begin
            a    = '0;
            a[d] = 1'b1;
            if ($urandom_range(0, 4) == 0)
               hold(bad_an[$urandom_range(0, 3)], pat[$urandom_range(0, 15)], $urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0)
               hold(a, pat[$urandom_range(0, 15)], $urandom_range(1, S - 1));
            v = $urandom_range(0, 19);
            s = (v < 16) ? pat[v] : 7'($urandom);
            hold(a, s, $urandom_range(S, S + 5));
         end
      end

      hold('0, 7'h00, 10);
      done = 1'b1;
   end

   int checks   = 0;
   int failures = 0;

   initial begin
      frame_t         f;
      logic [4*N-1:0] last_d = '0;
      logic [N-1:0]   last_e = '0;
      int             rst_n  = 0;
      while (!done) begin
         @(negedge clk);
         if (rst) begin
            rst_n++;
            last_d = '0;
            last_e = '0;
            if (rst_n >= 2) begin
               checks++;
               if (digits !== '0 || err !== '0 || frame_valid !== 1'b0) begin
                  failures++;
                  $display("FAIL reset_outputs cyc %0d: got digits=%h err=%b valid=%b want 0",
                           cyc, digits, err, frame_valid);
               end
            end
            continue;
         end
         rst_n = 0;
         if (frame_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_frame cyc %0d: got digits=%h err=%b want no pulse",
                        cyc, digits, err);
            end else begin
               f = exp_q.pop_front();
               checks++;
               if (f.at != cyc) begin
                  failures++;
                  $display("FAIL frame_time: got cyc %0d want cyc %0d", cyc, f.at);
               end
               checks++;
               if (digits !== f.d) begin
                  failures++;
                  $display("FAIL frame_digits cyc %0d: got %h want %h", cyc, digits, f.d);
               end
               checks++;
               if (err !== f.e) begin
                  failures++;
                  $display("FAIL frame_err cyc %0d: got %b want %b", cyc, err, f.e);
               end
               last_d = f.d;
               last_e = f.e;
            end
         end else begin
            checks++;
            if (digits !== last_d || err !== last_e || frame_valid !== 1'b0) begin
               failures++;
               $display("FAIL hold_between cyc %0d: got digits=%h err=%b valid=%b want %h %b 0",
                        cyc, digits, err, frame_valid, last_d, last_e);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_frames: got %0d pending want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by cyc %0d want finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
